// File: rtl/servant_ram_arb.sv
// Shares one RAM port between a CPU wishbone slave and an RX byte-stream DMA into a circular buffer.
// Define SERVANT_RAM_ARB_IRQ_EN to get a one-cycle o_irq pulse whenever the DMA pointer wraps.
module servant_ram_arb #(
  parameter int aw        = 10,
  parameter int BUF_BASE  = 'hC0,
  parameter int BUF_BYTES = 64
) (
  input  logic                         i_wb_clk,
  input  logic                         i_wb_rst,
  input  logic [aw-3:0]                i_cpu_adr,
  input  logic [31:0]                  i_cpu_dat,
  input  logic [3:0]                   i_cpu_sel,
  input  logic                         i_cpu_we,
  input  logic                         i_cpu_cyc,
  output logic [31:0]                  o_cpu_rdt,
  output logic                         o_cpu_ack,
  input  logic [7:0]                   i_rx_dat,
  input  logic                         i_rx_valid,
  output logic                         o_rx_ready,
  output logic [aw-3:0]                o_ram_adr,
  output logic [31:0]                  o_ram_dat,
  output logic [3:0]                   o_ram_sel,
  output logic                         o_ram_we,
  output logic                         o_ram_cyc,
  input  logic [31:0]                  i_ram_rdt,
  input  logic                         i_ram_ack,
  output logic [$clog2(BUF_BYTES)-1:0] o_wr_ptr,
  output logic                         o_irq
);
  localparam int PW = $clog2(BUF_BYTES);
  localparam int AW = aw - 2;

  typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;
  state_t state;
  logic   last_dma;

  logic [7:0] fifo [4];
  logic [1:0] rd_idx, wr_idx;
  logic [2:0] count;
  logic       full, empty, push, pop, is_cpu;

  assign full   = (count == 3'd4);
  assign empty  = (count == 3'd0);
  assign push   = i_rx_valid & ~full;
  assign pop    = (state == DMA) & i_ram_ack;
  assign is_cpu = (state == CPU);

  assign o_rx_ready = ~full;
  assign o_ram_cyc  = (state != IDLE);
  assign o_cpu_ack  = is_cpu & i_ram_ack;
  assign o_cpu_rdt  = i_ram_rdt;

  // Byte lane is picked by the low pointer bits; the byte is replicated on every lane.
  assign o_ram_adr = is_cpu ? i_cpu_adr : AW'(BUF_BASE) + AW'(o_wr_ptr >> 2);
  assign o_ram_dat = is_cpu ? i_cpu_dat : {4{fifo[rd_idx]}};
  assign o_ram_sel = is_cpu ? i_cpu_sel : 4'b0001 << o_wr_ptr[1:0];
  assign o_ram_we  = is_cpu ? i_cpu_we  : 1'b1;

  always_ff @(posedge i_wb_clk) begin
    if (push) fifo[wr_idx] <= i_rx_dat;
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state    <= IDLE;
      last_dma <= 1'b1;
      rd_idx   <= '0;
      wr_idx   <= '0;
      count    <= '0;
      o_wr_ptr <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 2'd1;
      if (pop) begin
        rd_idx   <= rd_idx + 2'd1;
        o_wr_ptr <= o_wr_ptr + PW'(1);
      end
      count <= count + {2'b0, push} - {2'b0, pop};
      case (state)
        IDLE: begin
          // A full FIFO wins outright; otherwise the CPU gets every other grant.
          if (full) begin
            state    <= DMA;
            last_dma <= 1'b1;
          end else if (i_cpu_cyc && (last_dma || empty)) begin
            state    <= CPU;
            last_dma <= 1'b0;
          end else if (!empty) begin
            state    <= DMA;
            last_dma <= 1'b1;
          end
        end
        CPU, DMA: if (i_ram_ack) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef SERVANT_RAM_ARB_IRQ_EN
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) o_irq <= 1'b0;
    else          o_irq <= pop & (&o_wr_ptr);
  end
`else
  assign o_irq = 1'b0;
`endif
endmodule

// File: doc/servant_ram_arb.md
SERVANT_RAM_ARB -- requirements
Module: servant_ram_arb

Interface
REQ-001 SHALL have parameter aw, default 10, meaning RAM byte-address width; word address is aw-2 bits.
REQ-002 SHALL have parameter BUF_BASE, default 'hC0, meaning word address of the RX circular buffer in RAM.
REQ-003 SHALL have parameter BUF_BYTES, default 64, meaning RX buffer size in bytes (power of two, ≥4).
REQ-004 SHALL have port i_wb_clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port i_wb_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have CPU slave ports i_cpu_adr in aw-2, i_cpu_dat in 32, i_cpu_sel in 4, i_cpu_we in 1, i_cpu_cyc in 1, o_cpu_rdt out 32, o_cpu_ack out 1.
REQ-007 SHALL have RX byte stream ports i_rx_dat in 8, i_rx_valid in 1, o_rx_ready out 1.
REQ-008 SHALL have RAM master ports o_ram_adr out aw-2, o_ram_dat out 32, o_ram_sel out 4, o_ram_we out 1, o_ram_cyc out 1, i_ram_rdt in 32, i_ram_ack in 1.
REQ-009 SHALL have o_wr_ptr  out  $clog2(BUF_BYTES)  current DMA byte offset in buffer; o_irq  out  1  wrap interrupt.

Function
REQ-010 SHALL contain a 4-entry byte FIFO; push when i_rx_valid & o_rx_ready; o_rx_ready = !full (no push when full even if pop same cycle).
REQ-011 SHALL implement states IDLE, CPU, DMA; o_ram_cyc = (state != IDLE).
REQ-012 IDLE: FIFO full -> DMA; else i_cpu_cyc and (last grant was DMA or FIFO empty) -> CPU; else FIFO non-empty -> DMA; else stay IDLE.
REQ-013 CPU/DMA: hold state and all RAM outputs stable until i_ram_ack, then go IDLE (cyc low ≥1 cycle between grants).
REQ-014 In CPU: o_ram_adr/dat/sel/we = CPU inputs; o_cpu_ack = i_ram_ack; o_cpu_rdt = i_ram_rdt (combinational); o_cpu_ack 0 in all other states.
REQ-015 In DMA: o_ram_adr = BUF_BASE + o_wr_ptr[msb:2]; o_ram_sel = 4'b0001 << o_wr_ptr[1:0]; o_ram_dat = {4{FIFO head}}; o_ram_we = 1.
REQ-016 On i_ram_ack in DMA: pop FIFO, o_wr_ptr increments by 1 modulo BUF_BYTES (BUF_BYTES-1 -> 0).
REQ-017 If i_cpu_cyc drops during CPU grant, the RAM cycle SHALL complete; o_cpu_ack still mirrors i_ram_ack.
REQ-018 Last-grant register SHALL update on entry to CPU or DMA; CPU grant latency from idle bus and empty FIFO = 1 cycle.
REQ-019 i_ram_ack outside a grant SHALL be ignored.

Reset
REQ-020 On i_wb_rst assertion (any cycle, including mid-grant): state IDLE, o_ram_cyc 0, o_cpu_ack 0, FIFO empty, o_rx_ready 1, o_wr_ptr 0, last grant = DMA, o_irq 0.
REQ-021 Bytes held in FIFO at reset SHALL be discarded; no partial RAM write is reissued.

Configuration
REQ-022 Macro SERVANT_RAM_ARB_IRQ_EN defined: o_irq pulses high exactly one cycle after the DMA ack that wraps o_wr_ptr to 0.
REQ-023 Macro SERVANT_RAM_ARB_IRQ_EN undefined: o_irq constant 0, no wrap-detect logic synthesized; all other behaviour identical.

Verification
REQ-024 Reset then CPU write adr 'h10 dat 'hDEADBEEF sel 'hF, no RX -> o_ram_cyc next cycle, o_cpu_ack with i_ram_ack, RAM word 'h10 = 'hDEADBEEF.
REQ-025 Push bytes 'h41,'h42,'h43,'h44 -> four DMA writes to word 'hC0 sel 1,2,4,8; word 'hC0 = 'h44434241; o_wr_ptr = 4.
REQ-026 CPU cyc held continuously while 8 RX bytes arrive -> grants alternate CPU/DMA; no CPU starvation; o_rx_ready low only while FIFO holds 4.
REQ-027 Push 65 bytes (BUF_BYTES 64) -> byte 65 written to word 'hC0 lane 0; o_wr_ptr = 1; with IRQ_EN one o_irq pulse after 64th ack, without o_irq stays 0.
REQ-028 Assert i_wb_rst during DMA grant with 3 bytes queued -> o_ram_cyc 0 immediately, o_rx_ready 1, o_wr_ptr 0; next byte 'h55 lands in word 'hC0 lane 0.
